// File: rtl/dh_vec_collect.sv
// dh_vec_collect
// Collects NUNIT per-unit derivative samples (signed Q2.14) into one packed
// per-timestep vector. Each vector is also summed into per-unit saturating
// accumulators, and the sums are emitted when the last timestep of a sequence
// completes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   clr         synchronous start-new-sequence clear (beats in_valid)
//   in_valid    sample strobe from the upstream derivative stage
//   in_data     signed sample for the current unit
//   seq_last    marks the current timestep as final (taken with the last unit)
//   in_ready    high when a sample can be accepted
//   dh_vec      packed per-timestep vector, unit i at [DATABIT*i +: DATABIT]
//   vec_valid   one-cycle pulse qualifying dh_vec
//   grad_vec    packed sequence-accumulated vector, same packing
//   grad_valid  one-cycle pulse qualifying grad_vec
//   sat_flag    sticky: some accumulator clamped
//   drop_err    sticky: in_valid arrived while in_ready was low
//   dbg_state   current FSM state (0 COLLECT, 1 ACC, 2 EMIT)
//
// Handshake: a sample is consumed on a rising edge where in_valid and
// in_ready are both high. There is no backpressure on the upstream stage.
// A sample offered while in_ready is low is lost and flagged in drop_err.
module dh_vec_collect #(
    parameter int DATABIT = 16,
    parameter int NUNIT   = 4,
    parameter int HTNUM   = NUNIT * DATABIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [DATABIT-1:0] in_data,
    input  logic               seq_last,
    output logic               in_ready,
    output logic [HTNUM-1:0]   dh_vec,
    output logic               vec_valid,
    output logic [HTNUM-1:0]   grad_vec,
    output logic               grad_valid,
    output logic               sat_flag,
    output logic               drop_err,
    output logic [1:0]         dbg_state
);

    localparam int IW = (NUNIT > 1) ? $clog2(NUNIT) : 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ACC     = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic               last_q;
    logic [DATABIT-1:0] slot_q [NUNIT];
    logic [DATABIT-1:0] acc_q  [NUNIT];
    logic [HTNUM-1:0]   dh_vec_q;
    logic [HTNUM-1:0]   grad_vec_q;
    logic               vec_valid_q;
    logic               grad_valid_q;
    logic               sat_flag_q;
    logic               drop_err_q;

    // Combinational helpers
    logic [HTNUM-1:0]   dh_pack_d;      // slots with the incoming sample merged in
    logic [DATABIT-1:0] acc_d [NUNIT];  // saturated acc + slot
    logic [HTNUM-1:0]   acc_pack_d;
    logic               sat_any_d;
    logic [DATABIT:0]   sum_d [NUNIT];

    assign in_ready   = (state_q == S_COLLECT) && !clr;
    assign dh_vec     = dh_vec_q;
    assign vec_valid  = vec_valid_q;
    assign grad_vec   = grad_vec_q;
    assign grad_valid = grad_valid_q;
    assign sat_flag   = sat_flag_q;
    assign drop_err   = drop_err_q;
    assign dbg_state  = state_q;

    always_comb begin
        dh_pack_d  = '0;
        acc_pack_d = '0;
        sat_any_d  = 1'b0;
        for (int i = 0; i < NUNIT; i++) begin
            // dh_vec is loaded on the edge that takes the final sample, so
            // that sample is merged in here rather than read back from slot_q.
            if (i == int'(idx_q)) begin
                dh_pack_d[i*DATABIT +: DATABIT] = in_data;
            end else begin
                dh_pack_d[i*DATABIT +: DATABIT] = slot_q[i];
            end

            // One guard bit. Overflow shows as the top two bits differing.
            // The top bit then gives the true sign of the sum.
            sum_d[i] = {acc_q[i][DATABIT-1], acc_q[i]} + {slot_q[i][DATABIT-1], slot_q[i]};
            if (sum_d[i][DATABIT] != sum_d[i][DATABIT-1]) begin
                sat_any_d = 1'b1;
                if (sum_d[i][DATABIT]) begin
                    acc_d[i] = {1'b1, {(DATABIT-1){1'b0}}};
                end else begin
                    acc_d[i] = {1'b0, {(DATABIT-1){1'b1}}};
                end
            end else begin
                acc_d[i] = sum_d[i][DATABIT-1:0];
            end
            acc_pack_d[i*DATABIT +: DATABIT] = acc_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_COLLECT;
            idx_q        <= '0;
            last_q       <= 1'b0;
            dh_vec_q     <= '0;
            grad_vec_q   <= '0;
            vec_valid_q  <= 1'b0;
            grad_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            drop_err_q   <= 1'b0;
            for (int i = 0; i < NUNIT; i++) begin
                slot_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            vec_valid_q  <= 1'b0;
            grad_valid_q <= 1'b0;
            if (clr) begin
                // The output vectors keep their values. Any in-flight
                // accumulate or emit is abandoned.
                state_q    <= S_COLLECT;
                idx_q      <= '0;
                last_q     <= 1'b0;
                sat_flag_q <= 1'b0;
                drop_err_q <= 1'b0;
                for (int i = 0; i < NUNIT; i++) begin
                    slot_q[i] <= '0;
                    acc_q[i]  <= '0;
                end
            end else begin
                if (in_valid && (state_q != S_COLLECT)) begin
                    drop_err_q <= 1'b1;
                end
                case (state_q)
                    S_COLLECT: begin
                        if (in_valid) begin
                            slot_q[idx_q] <= in_data;
                            if (idx_q == IW'(NUNIT - 1)) begin
                                idx_q       <= '0;
                                last_q      <= seq_last;
                                dh_vec_q    <= dh_pack_d;
                                vec_valid_q <= 1'b1;
                                state_q     <= S_ACC;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    S_ACC: begin
                        for (int i = 0; i < NUNIT; i++) begin
                            acc_q[i] <= acc_d[i];
                        end
                        if (sat_any_d) begin
                            sat_flag_q <= 1'b1;
                        end
                        if (last_q) begin
                            grad_vec_q   <= acc_pack_d;
                            grad_valid_q <= 1'b1;
                            state_q      <= S_EMIT;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                    S_EMIT: begin
                        for (int i = 0; i < NUNIT; i++) begin
                            acc_q[i] <= '0;
                        end
                        state_q <= S_COLLECT;
                    end
                    default: begin
                        state_q <= S_COLLECT;
                    end
                endcase
            end
        end
    end

endmodule
